// File: rtl/calc_pkg.sv
// Shared constants for the FSM calculator datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package calc_pkg;

  // Native operand width of the calculator datapath.
  localparam int DATA_W = 8;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder stage used in the ripple chain.
// Latency: purely combinational.
// Backpressure: none.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  // Propagate term is shared by the sum and the carry.
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/adder_8bit.sv
// Registered unsigned adder with carry-in; the top bit of Sum is the carry-out.
// Latency: 1 cycle from in_valid capture to out_valid; one operand pair per cycle.
// Backpressure: none; the consumer must take Sum whenever out_valid is high.
module adder_8bit
  import calc_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH:0]   Sum,
  output logic             out_valid
);

  // carry[i] feeds stage i; carry[WIDTH] is the final carry-out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_bits;
  logic [WIDTH:0]   sum_next;

  assign carry[0] = Cin;

  // Ripple chain: each stage hands its carry to the next one up.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    full_adder u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (carry[i]),
      .s  (sum_bits[i]),
      .co (carry[i+1])
    );
  end

  assign sum_next = {carry[WIDTH], sum_bits};

  // Output register: reset wins; idle cycles hold Sum so stray input values never reach it.
  always_ff @(posedge clk) begin
    if (rst) begin
      Sum       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Sum <= sum_next;
      end
    end
  end

endmodule

// File: tb/tb_adder_8bit.sv
// Scoreboard bench for adder_8bit: stimulus pushes expected sums, a monitor pops on out_valid.
// Latency: checks assume one cycle from capture to out_valid.
// Backpressure: none; every out_valid must match the oldest queued expectation.
module tb_adder_8bit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [8:0] sum;
  logic       out_valid;

  logic [8:0] exp_q[$];
  int         n_vec;
  int         n_fail;

  adder_8bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (a),
    .B         (b),
    .Cin       (cin),
    .Sum       (sum),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the rising edge; queue the expected result if it will be captured.
  task automatic drive(input logic v, input logic [7:0] va, input logic [7:0] vb,
                       input logic vc, input logic vr, input logic [8:0] expv);
    @(posedge clk);
    #1;
    rst      = vr;
    in_valid = v;
    a        = va;
    b        = vb;
    cin      = vc;
    if (v && !vr) exp_q.push_back(expv);
  endtask

  task automatic check_state(input string name, input logic [8:0] exp_sum, input logic exp_vld);
    n_vec++;
    if (sum !== exp_sum || out_valid !== exp_vld) begin
      n_fail++;
      $display("FAIL %s: got sum=%h out_valid=%b, want sum=%h out_valid=%b",
               name, sum, out_valid, exp_sum, exp_vld);
    end
  endtask

  // Monitor: every presented result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: got sum=%h with out_valid=1, want no output", sum);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if (sum !== e) begin
          n_fail++;
          $display("FAIL result: got sum=%h, want %h", sum, e);
        end
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of stimulus, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec    = 0;
    n_fail   = 0;
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 8'hFF;
    b        = 8'hFF;
    cin      = 1'b0;

    // 1. Reset held two cycles while in_valid is high: reset must win.
    @(negedge clk);
    check_state("reset_1", 9'h000, 1'b0);
    @(negedge clk);
    check_state("reset_2", 9'h000, 1'b0);

    // 2. First transaction.
    drive(1'b1, 8'h01, 8'h01, 1'b0, 1'b0, 9'h002);

    // 3. Back-to-back carry cases.
    drive(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 9'h100);
    drive(1'b1, 8'hAA, 8'h55, 1'b1, 1'b0, 9'h100);
    drive(1'b1, 8'h80, 8'h80, 1'b1, 1'b0, 9'h101);

    // 4. Extremes.
    drive(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF);
    drive(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 9'h000);

    // 5. 0F+F0 then idle cycles with changing operands: Sum must hold.
    drive(1'b1, 8'h0F, 8'hF0, 1'b0, 1'b0, 9'h0FF);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h11 + 8'(i * 37), 8'hE3 ^ 8'(i * 91), i[0], 1'b0, 9'h000);
      @(negedge clk);
      if (i > 0) check_state("hold", 9'h0FF, 1'b0);
    end

    // 6a. Reset the cycle after a capture: result shows once, then registers clear.
    drive(1'b1, 8'h80, 8'h80, 1'b0, 1'b0, 9'h100);
    drive(1'b0, 8'h80, 8'h80, 1'b0, 1'b1, 9'h000);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 9'h000);
    @(negedge clk);
    check_state("reset_after_capture", 9'h000, 1'b0);

    // 6b. Reset coincident with in_valid: nothing must be produced.
    drive(1'b1, 8'h80, 8'h80, 1'b1, 1'b1, 9'h000);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 9'h000);
    @(negedge clk);
    check_state("reset_wins", 9'h000, 1'b0);

    // Random sweep against a reference model, with some idle gaps.
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rc;
      logic       rv;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 3) != 0);
      drive(rv, ra, rb, rc, 1'b0, {1'b0, ra} + {1'b0, rb} + {8'h00, rc});
    end

    // Drain and confirm every expectation was consumed.
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 9'h000);
    @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d outstanding results, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
